// File: rtl/multi_chan_mailbox.sv
// Bank of independent FIFO mailboxes: one shared write port steered by channel index,
// one shared read port drained through a round-robin arbiter with valid/ready handshake.
module multi_chan_mailbox #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    wr_ready,
  input  logic [NUM_CH-1:0]       flush,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic                    err_bad_ch
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wrPtr_q [NUM_CH];
  logic [PTR_W-1:0] wrPtr_d [NUM_CH];
  logic [PTR_W-1:0] rdPtr_q [NUM_CH];
  logic [PTR_W-1:0] rdPtr_d [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [CNT_W-1:0] count_d [NUM_CH];
  logic [CH_W-1:0]  rrLast_q, rrLast_d;
  logic             errBadCh_q, errBadCh_d;

  logic [NUM_CH-1:0] wrFire;
  logic [NUM_CH-1:0] rdFireCh;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   scanCh;
  logic              anyValid;
  logic              chInRange;
  int                scanIdx;

  // Write acceptance never looks at the read side, so a full channel stays full this cycle.
  always_comb begin
    wr_ready  = 1'b0;
    wrFire    = '0;
    chInRange = (int'(wr_ch) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(wr_ch) == i) begin
        wr_ready = rst_n && (count_q[i] < CNT_W'(DEPTH)) && !flush[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      wrFire[i] = wr_valid && wr_ready && (int'(wr_ch) == i);
    end
  end

  // Round-robin scan starts just after the last granted channel.
  always_comb begin
    grant    = '0;
    anyValid = 1'b0;
    scanIdx  = 0;
    scanCh   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      scanIdx = (int'(rrLast_q) + k) % NUM_CH;
      scanCh  = CH_W'(scanIdx);
      if (!anyValid && (count_q[scanCh] != '0)) begin
        anyValid = 1'b1;
        grant    = scanCh;
      end
    end
  end

  always_comb begin
    out_valid = anyValid;
    out_ch    = grant;
    out_data  = anyValid ? mem_q[grant][rdPtr_q[grant]] : '0;
    rdFireCh  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rdFireCh[i] = anyValid && out_ready && (int'(grant) == i);
    end
    ch_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_count[i*CNT_W +: CNT_W] = count_q[i];
    end
    err_bad_ch = errBadCh_q;
  end

  // A flush overrides any write or read landing on the same channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrPtr_d[i] = wrPtr_q[i];
      rdPtr_d[i] = rdPtr_q[i];
      count_d[i] = count_q[i];
      if (flush[i]) begin
        wrPtr_d[i] = '0;
        rdPtr_d[i] = '0;
        count_d[i] = '0;
      end else begin
        if (wrFire[i]) wrPtr_d[i] = wrPtr_q[i] + 1'b1;
        if (rdFireCh[i]) rdPtr_d[i] = rdPtr_q[i] + 1'b1;
        count_d[i] = count_q[i] + CNT_W'(wrFire[i]) - CNT_W'(rdFireCh[i]);
      end
    end
    rrLast_d   = (anyValid && out_ready) ? grant : rrLast_q;
    errBadCh_d = errBadCh_q | (wr_valid && !chInRange);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
      rrLast_q   <= CH_W'(NUM_CH - 1);
      errBadCh_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wrPtr_q[i] <= wrPtr_d[i];
        rdPtr_q[i] <= rdPtr_d[i];
        count_q[i] <= count_d[i];
      end
      rrLast_q   <= rrLast_d;
      errBadCh_q <= errBadCh_d;
    end
  end

  // Storage needs no reset; occupancy counts decide what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wrFire[i]) mem_q[i][wrPtr_q[i]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_multi_chan_mailbox.sv
// Directed bench for multi_chan_mailbox with three channels of four 8-bit entries;
// expected values are hand-computed per step.
module tb_multi_chan_mailbox;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;

  logic                    clk;
  logic                    rst_n;
  logic                    wr_valid;
  logic [CH_W-1:0]         wr_ch;
  logic [WIDTH-1:0]        wr_data;
  logic                    wr_ready;
  logic [NUM_CH-1:0]       flush;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;
  logic [NUM_CH*CNT_W-1:0] ch_count;
  logic                    err_bad_ch;

  int passCount  = 0;
  int totalCount = 0;
  int failCount  = 0;

  multi_chan_mailbox #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ch_count  (ch_count),
    .err_bad_ch(err_bad_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_CH*CNT_W-1:0] packCounts(input int c0, input int c1, input int c2);
    return {3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic applyStimulus(input logic wv, input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d,
                               input logic [NUM_CH-1:0] fl, input logic ordy);
    wr_valid  = wv;
    wr_ch     = ch;
    wr_data   = d;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d);
    applyStimulus(1'b1, ch, d, '0, 1'b0);
    #1;
    checkOutput("wr_ready on write", 32'(wr_ready), 32'd1);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic readExpect(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    #1;
    checkOutput("read out_valid", 32'(out_valid), 32'd1);
    checkOutput("read out_ch", 32'(out_ch), 32'(ch));
    checkOutput("read out_data", 32'(out_data), 32'(d));
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    #2;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset ch_count", 32'(ch_count), 32'd0);
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset err_bad_ch", 32'(err_bad_ch), 32'd0);
    #10 rst_n = 1'b1;
    cycle();

    $display("[TB] independence");
    writeWord(2'd0, 8'h11);
    writeWord(2'd1, 8'h22);
    writeWord(2'd2, 8'h33);
    #1;
    checkOutput("indep ch_count", 32'(ch_count), 32'(packCounts(1, 1, 1)));
    for (int n = 0; n < 5; n++) begin
      checkOutput("hold out_ch", 32'(out_ch), 32'd0);
      checkOutput("hold out_data", 32'(out_data), 32'h11);
      cycle();
    end
    readExpect(2'd0, 8'h11);
    readExpect(2'd1, 8'h22);
    readExpect(2'd2, 8'h33);
    #1;
    checkOutput("indep drained", 32'(out_valid), 32'd0);

    $display("[TB] round-robin");
    writeWord(2'd0, 8'h01);
    writeWord(2'd0, 8'h02);
    writeWord(2'd0, 8'h03);
    writeWord(2'd2, 8'h21);
    writeWord(2'd2, 8'h22);
    writeWord(2'd2, 8'h23);
    readExpect(2'd0, 8'h01);
    readExpect(2'd2, 8'h21);
    readExpect(2'd0, 8'h02);
    readExpect(2'd2, 8'h22);
    readExpect(2'd0, 8'h03);
    readExpect(2'd2, 8'h23);
    writeWord(2'd0, 8'h04);
    writeWord(2'd0, 8'h05);
    writeWord(2'd2, 8'h24);
    writeWord(2'd2, 8'h25);
    applyStimulus(1'b1, 2'd1, 8'h55, '0, 1'b1);
    #1;
    checkOutput("rr mid wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rr mid out_ch", 32'(out_ch), 32'd0);
    checkOutput("rr mid out_data", 32'(out_data), 32'h04);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    readExpect(2'd1, 8'h55);
    readExpect(2'd2, 8'h24);
    readExpect(2'd0, 8'h05);
    readExpect(2'd2, 8'h25);
    #1;
    checkOutput("rr drained", 32'(out_valid), 32'd0);

    $display("[TB] fill/full");
    writeWord(2'd1, 8'hA0);
    writeWord(2'd1, 8'hA1);
    writeWord(2'd1, 8'hA2);
    writeWord(2'd1, 8'hA3);
    applyStimulus(1'b0, 2'd1, '0, '0, 1'b0);
    #1;
    checkOutput("full wr_ready ch1", 32'(wr_ready), 32'd0);
    applyStimulus(1'b1, 2'd1, 8'hA4, '0, 1'b0);
    #1;
    checkOutput("full 5th write", 32'(wr_ready), 32'd0);
    cycle();
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b0);
    #1;
    checkOutput("full ch_count", 32'(ch_count), 32'(packCounts(0, 4, 0)));
    checkOutput("full wr_ready ch0", 32'(wr_ready), 32'd1);
    applyStimulus(1'b0, 2'd2, '0, '0, 1'b0);
    #1;
    checkOutput("full wr_ready ch2", 32'(wr_ready), 32'd1);
    readExpect(2'd1, 8'hA0);
    readExpect(2'd1, 8'hA1);
    readExpect(2'd1, 8'hA2);
    readExpect(2'd1, 8'hA3);
    #1;
    checkOutput("full drained", 32'(out_valid), 32'd0);

    $display("[TB] simultaneous events");
    writeWord(2'd2, 8'h31);
    writeWord(2'd2, 8'h32);
    writeWord(2'd2, 8'h33);
    writeWord(2'd2, 8'h34);
    applyStimulus(1'b1, 2'd2, 8'h35, '0, 1'b1);
    #1;
    checkOutput("full rw wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("full rw out_ch", 32'(out_ch), 32'd2);
    checkOutput("full rw out_data", 32'(out_data), 32'h31);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    #1;
    checkOutput("full rw ch_count", 32'(ch_count), 32'(packCounts(0, 0, 3)));
    readExpect(2'd2, 8'h32);
    readExpect(2'd2, 8'h33);
    readExpect(2'd2, 8'h34);
    #1;
    checkOutput("full rw drained", 32'(out_valid), 32'd0);

    writeWord(2'd0, 8'h41);
    writeWord(2'd0, 8'h42);
    applyStimulus(1'b1, 2'd0, 8'h43, '0, 1'b1);
    #1;
    checkOutput("same rw wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("same rw out_data", 32'(out_data), 32'h41);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    #1;
    checkOutput("same rw ch_count", 32'(ch_count), 32'(packCounts(2, 0, 0)));
    readExpect(2'd0, 8'h42);
    readExpect(2'd0, 8'h43);

    writeWord(2'd1, 8'h51);
    applyStimulus(1'b1, 2'd1, 8'h52, 3'b010, 1'b0);
    #1;
    checkOutput("flush wr_ready", 32'(wr_ready), 32'd0);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    #1;
    checkOutput("flush ch_count", 32'(ch_count), 32'd0);
    checkOutput("flush out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush err_bad_ch", 32'(err_bad_ch), 32'd0);

    $display("[TB] bad index");
    writeWord(2'd0, 8'h61);
    applyStimulus(1'b1, 2'd3, 8'h99, '0, 1'b0);
    #1;
    checkOutput("bad wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("bad err before edge", 32'(err_bad_ch), 32'd0);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    #1;
    checkOutput("bad err set", 32'(err_bad_ch), 32'd1);
    checkOutput("bad ch_count", 32'(ch_count), 32'(packCounts(1, 0, 0)));
    cycle();
    cycle();
    cycle();
    checkOutput("bad err sticky", 32'(err_bad_ch), 32'd1);

    $display("[TB] async reset");
    writeWord(2'd1, 8'h71);
    writeWord(2'd2, 8'h72);
    #1;
    checkOutput("pre-reset ch_count", 32'(ch_count), 32'(packCounts(1, 1, 1)));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", 32'(out_valid), 32'd0);
    checkOutput("async ch_count", 32'(ch_count), 32'd0);
    checkOutput("async out_ch", 32'(out_ch), 32'd0);
    checkOutput("async out_data", 32'(out_data), 32'd0);
    checkOutput("async wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("async err_bad_ch", 32'(err_bad_ch), 32'd0);
    #2 rst_n = 1'b1;
    cycle();
    writeWord(2'd2, 8'h81);
    #1;
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd1);
    checkOutput("post-reset out_ch", 32'(out_ch), 32'd2);
    checkOutput("post-reset out_data", 32'(out_data), 32'h81);
    checkOutput("post-reset ch_count", 32'(ch_count), 32'(packCounts(0, 0, 1)));

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
